// File: rtl/add_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder sequencer.
package add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add16_seq_if.sv
// Operand/result handshake bundle for add16_seq; the sub line exists only
// when ADD16_SEQ_SUB_EN is defined.
interface add16_seq_if #(parameter int NIBBLES = 4);
    import add_pkg::*;

    localparam int W = NIB_W * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADD16_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

`ifdef ADD16_SEQ_SUB_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/add4.sv
// 4-bit ripple-carry adder slice driven one nibble per cycle by add16_seq.
module add4
    import add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] carry;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[NIB_W];
    end

endmodule

// File: rtl/add16_seq.sv
// Multi-cycle adder sequencer: feeds add4 one nibble per cycle through a
// carry register. Subtraction is available with ADD16_SEQ_SUB_EN defined.
module add16_seq
    import add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    add16_seq_if.slave  bus,
    output logic        busy
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sub_q;
    logic             carry_q;
    logic [CNT_W-1:0] nib_cnt;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             sub_in;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] add_sum;
    logic             add_cout;

`ifdef ADD16_SEQ_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction is A + ~B + 1: invert every B nibble; the +1 is the seeded carry.
    assign a_nib = a_q[NIB_W*nib_cnt +: NIB_W];
    assign b_nib = b_q[NIB_W*nib_cnt +: NIB_W] ^ {NIB_W{sub_q}};

    add4 u_add4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            nib_cnt     <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        sub_q      <= sub_in;
                        carry_q    <= sub_in ? 1'b1 : bus.cin;
                        nib_cnt    <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[NIB_W*nib_cnt +: NIB_W] <= add_sum;
                    carry_q                       <= add_cout;
                    if (nib_cnt == LAST_NIB) begin
                        cout_q      <= add_cout;
                        nib_cnt     <= '0;
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        nib_cnt <= nib_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = busy_q;

endmodule
